// File: rtl/dmrl3_signal_monitor.sv
// Frame checker for the DMRL3 control-signal imitator: measures each sinhr-to-sinhr
// frame and publishes period, width, pulse counts, first-rise offsets and error flags.
module dmrl3_signal_monitor #(
  parameter int unsigned EXP_PERIOD     = 15001,
  parameter int unsigned PERIOD_TOL     = 2,
  parameter int unsigned EXP_SINHR_W    = 50,
  parameter int unsigned EXP_MOD_PULSES = 3,
  parameter int unsigned EXP_GEN_PULSES = 3,
  parameter int unsigned TIMEOUT        = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sinhr,
  input  logic        upr_mod,
  input  logic        upr_gen,
  output logic        frame_valid,
  output logic [15:0] period,
  output logic [15:0] sinhr_width,
  output logic [3:0]  mod_cnt,
  output logic [3:0]  gen_cnt,
  output logic [15:0] mod_first,
  output logic [15:0] gen_first,
  output logic        err_period,
  output logic        err_width,
  output logic        err_mod,
  output logic        err_gen,
  output logic        sync_lost,
  output logic [15:0] frame_num
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0]  NONE      = '1;
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [W-1:0]  PERIOD_HI = W'(EXP_PERIOD + PERIOD_TOL);
  localparam logic [W-1:0]  PERIOD_LO = W'(EXP_PERIOD - PERIOD_TOL);
  localparam logic [W-1:0]  TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0]  EXP_W     = W'(EXP_SINHR_W);
  localparam logic [CW-1:0] EXP_MOD   = CW'(EXP_MOD_PULSES);
  localparam logic [CW-1:0] EXP_GEN   = CW'(EXP_GEN_PULSES);

  typedef enum logic {HUNT, MEASURE} state_t;

  state_t        state;
  logic          primed;
  logic          sinhr_d, mod_d, gen_d;
  logic [W-1:0]  ofs;
  logic [CW-1:0] acc_mod_cnt, acc_gen_cnt;
  logic [W-1:0]  acc_mod_first, acc_gen_first, acc_width;
  logic          width_seen;

  logic          sinhr_rise, sinhr_fall, mod_rise, gen_rise;
  logic [W-1:0]  ofs_inc, period_c;
  logic [CW-1:0] mod_cnt_inc, gen_cnt_inc;

  // primed masks edges in the first cycle after reset, so a level already high is not a rise
  assign sinhr_rise = primed & sinhr & ~sinhr_d;
  assign sinhr_fall = primed & ~sinhr & sinhr_d;
  assign mod_rise   = primed & upr_mod & ~mod_d;
  assign gen_rise   = primed & upr_gen & ~gen_d;

  assign ofs_inc     = (ofs == NONE) ? ofs : ofs + W'(1);
  assign period_c    = ofs + W'(1);
  assign mod_cnt_inc = (acc_mod_cnt == CNT_MAX) ? acc_mod_cnt : acc_mod_cnt + CW'(1);
  assign gen_cnt_inc = (acc_gen_cnt == CNT_MAX) ? acc_gen_cnt : acc_gen_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= HUNT;
      primed        <= 1'b0;
      sinhr_d       <= 1'b0;
      mod_d         <= 1'b0;
      gen_d         <= 1'b0;
      ofs           <= '0;
      acc_mod_cnt   <= '0;
      acc_gen_cnt   <= '0;
      acc_mod_first <= NONE;
      acc_gen_first <= NONE;
      acc_width     <= NONE;
      width_seen    <= 1'b0;
      frame_valid   <= 1'b0;
      period        <= '0;
      sinhr_width   <= '0;
      mod_cnt       <= '0;
      gen_cnt       <= '0;
      mod_first     <= NONE;
      gen_first     <= NONE;
      err_period    <= 1'b0;
      err_width     <= 1'b0;
      err_mod       <= 1'b0;
      err_gen       <= 1'b0;
      sync_lost     <= 1'b1;
      frame_num     <= '0;
    end else begin
      primed      <= 1'b1;
      sinhr_d     <= sinhr;
      mod_d       <= upr_mod;
      gen_d       <= upr_gen;
      frame_valid <= 1'b0;
      case (state)
        HUNT: begin
          if (sinhr_rise) begin
            state         <= MEASURE;
            ofs           <= W'(1);
            acc_mod_cnt   <= CW'(mod_rise);
            acc_gen_cnt   <= CW'(gen_rise);
            acc_mod_first <= mod_rise ? '0 : NONE;
            acc_gen_first <= gen_rise ? '0 : NONE;
            acc_width     <= NONE;
            width_seen    <= 1'b0;
          end else begin
            ofs           <= '0;
            acc_mod_cnt   <= '0;
            acc_gen_cnt   <= '0;
            acc_mod_first <= NONE;
            acc_gen_first <= NONE;
            acc_width     <= NONE;
            width_seen    <= 1'b0;
          end
        end
        MEASURE: begin
          if (sinhr_rise) begin
            // publish the closing frame and restart; coincident control rises open the new frame
            frame_valid   <= 1'b1;
            period        <= period_c;
            sinhr_width   <= acc_width;
            mod_cnt       <= acc_mod_cnt;
            gen_cnt       <= acc_gen_cnt;
            mod_first     <= acc_mod_first;
            gen_first     <= acc_gen_first;
            err_period    <= (period_c > PERIOD_HI) || (period_c < PERIOD_LO);
            err_width     <= (acc_width != EXP_W);
            err_mod       <= (acc_mod_cnt != EXP_MOD);
            err_gen       <= (acc_gen_cnt != EXP_GEN);
            sync_lost     <= 1'b0;
            frame_num     <= frame_num + W'(1);
            ofs           <= W'(1);
            acc_mod_cnt   <= CW'(mod_rise);
            acc_gen_cnt   <= CW'(gen_rise);
            acc_mod_first <= mod_rise ? '0 : NONE;
            acc_gen_first <= gen_rise ? '0 : NONE;
            acc_width     <= NONE;
            width_seen    <= 1'b0;
          end else if (ofs == TIMEOUT_W) begin
            state         <= HUNT;
            sync_lost     <= 1'b1;
            ofs           <= '0;
            acc_mod_cnt   <= '0;
            acc_gen_cnt   <= '0;
            acc_mod_first <= NONE;
            acc_gen_first <= NONE;
            acc_width     <= NONE;
            width_seen    <= 1'b0;
          end else begin
            ofs <= ofs_inc;
            if (mod_rise) begin
              if (acc_mod_cnt == '0) acc_mod_first <= ofs;
              acc_mod_cnt <= mod_cnt_inc;
            end
            if (gen_rise) begin
              if (acc_gen_cnt == '0) acc_gen_first <= ofs;
              acc_gen_cnt <= gen_cnt_inc;
            end
            if (sinhr_fall && !width_seen) begin
              acc_width  <= ofs;
              width_seen <= 1'b1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_dmrl3_signal_monitor.sv
// Scoreboard bench for dmrl3_signal_monitor: a per-cycle event-list model predicts each
// published frame; a monitor process checks strobes, results, held values and sync_lost.
module tb_dmrl3_signal_monitor;

  localparam int P   = 1501;
  localparam int TOL = 2;
  localparam int SW  = 50;
  localparam int NM  = 3;
  localparam int NG  = 3;
  localparam int TO  = 2000;
  localparam int PW  = 8;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] width;
    logic [3:0]  mod_cnt;
    logic [3:0]  gen_cnt;
    logic [15:0] mod_first;
    logic [15:0] gen_first;
    logic        err_p;
    logic        err_w;
    logic        err_m;
    logic        err_g;
    logic [15:0] frame_num;
  } res_t;

  localparam res_t RST_RES = '{period: 16'h0, width: 16'h0, mod_cnt: 4'h0, gen_cnt: 4'h0,
                               mod_first: 16'hFFFF, gen_first: 16'hFFFF, err_p: 1'b0,
                               err_w: 1'b0, err_m: 1'b0, err_g: 1'b0, frame_num: 16'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sinhr = 1'b0, upr_mod = 1'b0, upr_gen = 1'b0;
  logic        frame_valid, err_period, err_width, err_mod, err_gen, sync_lost;
  logic [15:0] period, sinhr_width, mod_first, gen_first, frame_num;
  logic [3:0]  mod_cnt, gen_cnt;
  res_t dut_res;

  dmrl3_signal_monitor #(
    .EXP_PERIOD(P), .PERIOD_TOL(TOL), .EXP_SINHR_W(SW),
    .EXP_MOD_PULSES(NM), .EXP_GEN_PULSES(NG), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sinhr(sinhr), .upr_mod(upr_mod), .upr_gen(upr_gen),
    .frame_valid(frame_valid), .period(period), .sinhr_width(sinhr_width),
    .mod_cnt(mod_cnt), .gen_cnt(gen_cnt), .mod_first(mod_first), .gen_first(gen_first),
    .err_period(err_period), .err_width(err_width), .err_mod(err_mod), .err_gen(err_gen),
    .sync_lost(sync_lost), .frame_num(frame_num)
  );

  always #5 clk = ~clk;

  assign dut_res = {period, sinhr_width, mod_cnt, gen_cnt, mod_first, gen_first,
                    err_period, err_width, err_mod, err_gen, frame_num};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  // ---------------- reference model: absolute event times per frame ----------------
  res_t sb_q[$];
  logic exp_sync = 1'b1;
  int   cyc = 0;
  bit   m_primed = 0, m_armed = 0;
  logic m_ps = 0, m_pm = 0, m_pg = 0;
  int   m_start = 0, m_fall = -1, m_fnum = 0;
  int   mod_t[$], gen_t[$];

  task automatic model_publish();
    res_t r;
    int   per;
    per         = cyc - m_start + 1;
    r.period    = 16'(per);
    r.width     = (m_fall < 0) ? 16'hFFFF : 16'(m_fall - m_start);
    r.mod_cnt   = (mod_t.size() > 15) ? 4'd15 : 4'(mod_t.size());
    r.gen_cnt   = (gen_t.size() > 15) ? 4'd15 : 4'(gen_t.size());
    r.mod_first = (mod_t.size() > 0) ? 16'(mod_t[0] - m_start) : 16'hFFFF;
    r.gen_first = (gen_t.size() > 0) ? 16'(gen_t[0] - m_start) : 16'hFFFF;
    r.err_p     = (per > P + TOL) || (per < P - TOL);
    r.err_w     = (r.width != 16'(SW));
    r.err_m     = (r.mod_cnt != 4'(NM));
    r.err_g     = (r.gen_cnt != 4'(NG));
    m_fnum      = (m_fnum + 1) % 65536;
    r.frame_num = 16'(m_fnum);
    exp_sync    = 1'b0;
    sb_q.push_back(r);
  endtask

  task automatic model_step();
    bit rs, fs, rm, rg;
    cyc++;
    if (!rst_n) begin
      m_primed = 0; m_armed = 0; m_fnum = 0; exp_sync = 1'b1;
      sb_q.delete();
      return;
    end
    rs = m_primed && sinhr && !m_ps;
    fs = m_primed && !sinhr && m_ps;
    rm = m_primed && upr_mod && !m_pm;
    rg = m_primed && upr_gen && !m_pg;
    if (rs) begin
      if (m_armed) model_publish();
      m_armed = 1; m_start = cyc; m_fall = -1;
      mod_t.delete(); gen_t.delete();
      if (rm) mod_t.push_back(cyc);
      if (rg) gen_t.push_back(cyc);
    end else if (m_armed) begin
      if (cyc - m_start == TO) begin
        m_armed  = 0;
        exp_sync = 1'b1;
      end else begin
        if (rm) mod_t.push_back(cyc);
        if (rg) gen_t.push_back(cyc);
        if (fs && m_fall < 0) m_fall = cyc;
      end
    end
    m_ps = sinhr; m_pm = upr_mod; m_pg = upr_gen;
    m_primed = 1;
  endtask

  // ---------------- monitor ----------------
  res_t last = RST_RES;
  res_t item;
  logic rst_seen;
  bit   exp_v;

  always @(posedge clk) begin
    rst_seen = rst_n;
    #1;
    if (!rst_seen) begin
      chk("reset_results", 128'(dut_res), 128'(RST_RES));
      chk("reset_sync_lost", 128'(sync_lost), 128'(1'b1));
      chk("reset_frame_valid", 128'(frame_valid), 128'(1'b0));
      last = RST_RES;
    end else begin
      exp_v = (sb_q.size() > 0);
      chk("frame_valid", 128'(frame_valid), 128'(exp_v));
      if (exp_v) begin
        item = sb_q.pop_front();
        if (frame_valid) chk("frame_result", 128'(dut_res), 128'(item));
        last = item;
      end else begin
        chk("held_result", 128'(dut_res), 128'(last));
      end
      chk("sync_lost", 128'(sync_lost), 128'(exp_sync));
    end
  end

  // ---------------- stimulus ----------------
  int mod_q[$], gen_q[$];
  int mod_left = 0, gen_left = 0;

  task automatic step(input logic s, input logic mk, input logic gk);
    @(negedge clk);
    if (mk) mod_left = PW;
    if (gk) gen_left = PW;
    sinhr   = s;
    upr_mod = (mod_left > 0);
    upr_gen = (gen_left > 0);
    if (mod_left > 0) mod_left--;
    if (gen_left > 0) gen_left--;
    model_step();
  endtask

  // one frame of length len (rise-to-rise spacing len-1), truncated after cut cycles
  task automatic run_frame(input int len, input int sw, input int cut);
    for (int k = 0; k < len - 1 && k < cut; k++) begin
      bit mk, gk;
      mk = 0; gk = 0;
      foreach (mod_q[i]) if (mod_q[i] == k) mk = 1;
      foreach (gen_q[i]) if (gen_q[i] == k) gk = 1;
      step(k < sw, mk, gk);
    end
  endtask

  // inputs held high through reset and just after it: no edge may be seen
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; sinhr = 1'b1; upr_mod = 1'b1; upr_gen = 1'b1;
      mod_left = 0; gen_left = 0;
      model_step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_nominal();
    mod_q = '{0, 405, 1250};
    gen_q = '{17, 420, 1270};
  endtask

  initial begin
    do_reset(4);

    set_nominal();
    repeat (3) run_frame(P, SW, P);

    run_frame(P + 3, SW, P + 3);
    run_frame(P + 2, SW, P + 2);

    gen_q = '{17, 1270};
    run_frame(P, SW - 1, P);

    mod_q.delete();
    for (int i = 0; i < 20; i++) mod_q.push_back(100 + 40 * i);
    gen_q.delete();
    run_frame(P, SW, P);

    for (int r = 0; r < 4; r++) begin
      int len, sw, n;
      len = P - 4 + int'($urandom_range(0, 8));
      sw  = SW - 2 + int'($urandom_range(0, 4));
      mod_q.delete(); gen_q.delete();
      n = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) mod_q.push_back(int'($urandom_range(0, len - 2)));
      n = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) gen_q.push_back(int'($urandom_range(0, len - 2)));
      run_frame(len, sw, len);
    end

    set_nominal();
    run_frame(P, SW, P);
    for (int i = 0; i < TO + 50; i++) step(1'b0, 1'b0, 1'b0);
    run_frame(P, SW, P);
    run_frame(P, SW, P);

    run_frame(P, SW, 700);
    do_reset(3);
    run_frame(P, SW, P);
    run_frame(P, SW, P);
    run_frame(P, SW, 60);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    chk("final_frame_num", 128'(frame_num), 128'(16'd2));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
